// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with direct and prescaled scan modes
module onehot_scan_decoder #(
    parameter int SEL_W    = 3,
    parameter int OUT_W    = 8,
    parameter int STEP_CYC = 4,
    parameter int CNT_W    = $clog2(STEP_CYC + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             range_err,
    output logic             wrap
);
    if (OUT_W < 2 || OUT_W > (1 << SEL_W)) begin : g_bad_out_w
        $error("OUT_W must be within 2..2**SEL_W");
    end
    if (STEP_CYC < 1) begin : g_bad_step
        $error("STEP_CYC must be at least 1");
    end

    localparam logic [SEL_W-1:0] IDX_MAX   = SEL_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(STEP_CYC - 1);

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        return {{(OUT_W-1){1'b0}}, 1'b1} << i;
    endfunction

    logic             mode_d;
    logic [CNT_W-1:0] presc, presc_n;
    logic [SEL_W-1:0] idx_n, idx_up, idx_dn, idx_step;
    logic [OUT_W-1:0] out_n;
    logic             err_n, wrap_n;
    logic             mode_chg, sel_ok, step;

    assign mode_chg = mode != mode_d;
    assign sel_ok   = int'(sel) < OUT_W;
    assign step     = presc == PRESC_MAX;
    assign idx_up   = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    assign idx_dn   = (idx == '0) ? IDX_MAX : idx - 1'b1;
    assign idx_step = dir ? idx_dn : idx_up;

    // A mode change re-shows the held index so a scan resumes from the last valid direct code.
    always_comb begin
        presc_n = presc;
        idx_n   = idx;
        out_n   = out;
        err_n   = range_err;
        wrap_n  = 1'b0;
        if (mode_chg) begin
            presc_n = '0;
            out_n   = onehot(idx);
            err_n   = 1'b0;
        end else if (en && !mode) begin
            idx_n = sel_ok ? sel : idx;
            out_n = sel_ok ? onehot(sel) : '0;
            err_n = !sel_ok;
        end else if (en && step) begin
            presc_n = '0;
            idx_n   = idx_step;
            out_n   = onehot(idx_step);
            err_n   = 1'b0;
            wrap_n  = dir ? (idx == '0) : (idx == IDX_MAX);
        end else if (en) begin
            presc_n = presc + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_d    <= 1'b0;
            presc     <= '0;
            idx       <= '0;
            out       <= onehot('0);
            range_err <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            mode_d    <= mode;
            presc     <= presc_n;
            idx       <= idx_n;
            out       <= out_n;
            range_err <= err_n;
            wrap      <= wrap_n;
        end
    end

    a_onehot: assert property (@(posedge sys_clk) disable iff (sys_rst)
        range_err ? (out == '0) : $onehot(out));
    a_idx_range: assert property (@(posedge sys_clk) disable iff (sys_rst) idx <= IDX_MAX);
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed vectors for the main configuration and two parameter corners
module tb_onehot_scan_decoder;
    logic       clk = 1'b0;
    logic       rst, en, mode, dir;
    logic [2:0] sel;
    logic [5:0] out;
    logic [2:0] idx;
    logic       range_err, wrap;
    logic [2:0] sel1 = '0;
    logic [7:0] out1;
    logic [2:0] idx1;
    logic       err1, wrap1;
    logic [0:0] sel2 = '0;
    logic [1:0] out2;
    logic [0:0] idx2;
    logic       err2, wrap2;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    onehot_scan_decoder #(.SEL_W(3), .OUT_W(6), .STEP_CYC(4)) u0 (
        .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode), .dir(dir), .sel(sel),
        .out(out), .idx(idx), .range_err(range_err), .wrap(wrap));
    onehot_scan_decoder #(.SEL_W(3), .OUT_W(8), .STEP_CYC(1)) u1 (
        .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode), .dir(dir), .sel(sel1),
        .out(out1), .idx(idx1), .range_err(err1), .wrap(wrap1));
    onehot_scan_decoder #(.SEL_W(1), .OUT_W(2), .STEP_CYC(1)) u2 (
        .sys_clk(clk), .sys_rst(rst), .en(en), .mode(mode), .dir(dir), .sel(sel2),
        .out(out2), .idx(idx2), .range_err(err2), .wrap(wrap2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // STEP_CYC-1 counting clocks hold idx, then the step clock moves it.
    task automatic scan_step(input int prev, input int ei, input logic ew);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("scan_hold_idx", 32'(idx), 32'(prev));
            chk("scan_hold_wrap", 32'(wrap), 0);
        end
        tick();
        chk("scan_idx", 32'(idx), 32'(ei));
        chk("scan_out", 32'(out), 32'(1) << ei);
        chk("scan_wrap", 32'(wrap), 32'(ew));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; dir = 1'b0; sel = '0;
        repeat (2) tick();
        chk("rst_out", 32'(out), 1);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_err", 32'(range_err), 0);
        chk("rst_wrap", 32'(wrap), 0);
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            sel = 3'(s);
            tick();
            chk("dir_out", 32'(out), 32'(1) << s);
            chk("dir_idx", 32'(idx), 32'(s));
            chk("dir_err", 32'(range_err), 0);
        end
        sel = 3'd2; tick();
        sel = 3'd6; tick();
        chk("err6_out", 32'(out), 0);
        chk("err6_flag", 32'(range_err), 1);
        chk("err6_idx", 32'(idx), 2);
        sel = 3'd7; tick();
        chk("err7_out", 32'(out), 0);
        chk("err7_flag", 32'(range_err), 1);
        chk("err7_idx", 32'(idx), 2);
        sel = 3'd3; tick();
        chk("rec_out", 32'(out), 32'b001000);
        chk("rec_idx", 32'(idx), 3);
        chk("rec_err", 32'(range_err), 0);
        sel = 3'd4; tick();
        mode = 1'b1; tick();
        chk("mchg_out", 32'(out), 32'b010000);
        chk("mchg_idx", 32'(idx), 4);
        chk("mchg_wrap", 32'(wrap), 0);
        scan_step(4, 5, 1'b0);
        scan_step(5, 0, 1'b1);
        scan_step(0, 1, 1'b0);
        dir = 1'b1;
        scan_step(1, 0, 1'b0);
        scan_step(0, 5, 1'b1);
        tick(); tick();
        en = 1'b0;
        repeat (10) tick();
        chk("gate_idx", 32'(idx), 5);
        chk("gate_out", 32'(out), 32'b100000);
        chk("gate_wrap", 32'(wrap), 0);
        en = 1'b1;
        tick();
        chk("resume_hold", 32'(idx), 5);
        tick();
        chk("resume_step", 32'(idx), 4);
        chk("resume_out", 32'(out), 32'b010000);
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_out", 32'(out), 1);
        chk("arst_idx", 32'(idx), 0);
        chk("arst_wrap", 32'(wrap), 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_hold", 32'(idx), 0);
        tick();
        chk("post_rst_step", 32'(idx), 5);
        chk("post_rst_wrap", 32'(wrap), 1);
        rst = 1'b1; dir = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("c1_mchg_idx", 32'(idx1), 0);
        chk("c2_mchg_out", 32'(out2), 32'b01);
        for (int k = 2; k <= 10; k++) begin
            tick();
            chk("c1_idx", 32'(idx1), 32'((k - 1) % 8));
            chk("c1_out", 32'(out1), 32'(1) << ((k - 1) % 8));
            chk("c1_wrap", 32'(wrap1), 32'(k == 9));
            chk("c1_err", 32'(err1), 0);
            chk("c2_out", 32'(out2), (k % 2 == 0) ? 32'b10 : 32'b01);
            chk("c2_wrap", 32'(wrap2), 32'(k % 2 == 1));
            chk("c2_err", 32'(err2), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
